// File: rtl/cic_interp_pdm.sv
// cic_interp_pdm: N-stage CIC interpolator feeding a first-order
// sigma-delta modulator that emits one PDM bit per clk_en strobe.
module cic_interp_pdm #(
   parameter int N     = 3,
   parameter int IN_W  = 16,
   parameter int ACC_W = 48
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clk_en,
   input  logic [IN_W-1:0] din,
   input  logic            din_valid,
   output logic            din_rdy,
   input  logic [15:0]     int_num,
   input  logic            rate_we,
   input  logic [5:0]      norm_shift,
   output logic            dout,
   output logic            dout_vld,
   output logic            underrun
);

   logic [15:0]             r_q;
   logic [5:0]              sh_q;
   logic [15:0]             phase;
   logic [IN_W-1:0]         hold_q;
   logic [IN_W-1:0]         last_q;
   logic                    hold_full;
   logic signed [ACC_W-1:0] dly_q [N];
   logic signed [ACC_W-1:0] up_q;
   logic signed [ACC_W-1:0] integ_q [N];
   logic signed [IN_W+2:0]  sd_acc;

   logic                    xfer;
   logic                    last_ph;
   logic                    consume;
   logic                    starve;
   logic [IN_W-1:0]         sample;
   logic signed [ACC_W-1:0] cx [N+1];
   logic signed [ACC_W-1:0] shifted;
   logic [IN_W-1:0]         y;
   logic [IN_W-1:0]         fb;
   logic signed [IN_W+2:0]  sd_sum;

   assign din_rdy = ~hold_full;
   assign xfer    = din_valid & ~hold_full;
   assign last_ph = (phase == r_q - 16'd1);
   assign consume = clk_en & last_ph;
   assign starve  = ~hold_full & ~xfer;

   // An empty register with a same-cycle transfer passes din straight through
   always_comb begin
      sample = last_q;
      if (hold_full)
         sample = hold_q;
      else if (xfer)
         sample = din;
   end

   always_comb begin
      cx[0] = {{(ACC_W-IN_W){sample[IN_W-1]}}, sample};
      for (int i = 0; i < N; i++)
         cx[i+1] = cx[i] - dly_q[i];
   end

   assign shifted = integ_q[N-1] >>> sh_q;

   always_comb begin
      y = shifted[IN_W-1:0];
      if (shifted[ACC_W-1:IN_W-1] !=
          {(ACC_W-IN_W+1){shifted[ACC_W-1]}})
         y = shifted[ACC_W-1] ? {1'b1, {(IN_W-1){1'b0}}}
                              : {1'b0, {(IN_W-1){1'b1}}};
   end

   assign fb = dout ? {1'b0, {(IN_W-1){1'b1}}}
                    : {1'b1, {(IN_W-1){1'b0}}};

   assign sd_sum = sd_acc
                 + $signed({{3{y[IN_W-1]}}, y})
                 - $signed({{3{fb[IN_W-1]}}, fb});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q       <= 16'd4;
         sh_q      <= 6'd4;
         phase     <= '0;
         hold_q    <= '0;
         last_q    <= '0;
         hold_full <= 1'b0;
         up_q      <= '0;
         sd_acc    <= '0;
         dout      <= 1'b0;
         dout_vld  <= 1'b0;
         underrun  <= 1'b0;
         for (int i = 0; i < N; i++) begin
            dly_q[i]   <= '0;
            integ_q[i] <= '0;
         end
      end else if (rate_we) begin
         r_q       <= (int_num < 16'd2) ? 16'd2 : int_num;
         sh_q      <= norm_shift;
         phase     <= '0;
         last_q    <= '0;
         hold_full <= 1'b0;
         up_q      <= '0;
         sd_acc    <= '0;
         dout      <= 1'b0;
         dout_vld  <= clk_en;
         for (int i = 0; i < N; i++) begin
            dly_q[i]   <= '0;
            integ_q[i] <= '0;
         end
      end else begin
         dout_vld <= clk_en;
         if (consume) begin
            hold_full <= 1'b0;
            last_q    <= sample;
            up_q      <= cx[N];
            for (int i = 0; i < N; i++)
               dly_q[i] <= cx[i];
            if (starve)
               underrun <= 1'b1;
         end else if (xfer) begin
            hold_q    <= din;
            hold_full <= 1'b1;
         end
         if (clk_en) begin
            phase <= last_ph ? '0 : phase + 16'd1;
            // zero-stuffing: the comb output enters only on phase 0
            integ_q[0] <= integ_q[0] + ((phase == '0) ? up_q : '0);
            for (int i = 1; i < N; i++)
               integ_q[i] <= integ_q[i] + integ_q[i-1];
            sd_acc <= sd_sum;
            dout   <= ~sd_sum[IN_W+2];
         end
      end
   end

endmodule

// File: tb/tb_cic_interp_pdm.sv
// Directed bench for cic_interp_pdm: DC density, saturation,
// underrun, rate change, gated strobe and reset behaviour.
module tb_cic_interp_pdm;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_en;
   logic [15:0] din;
   logic        din_valid;
   logic        din_rdy;
   logic [15:0] int_num;
   logic        rate_we;
   logic [5:0]  norm_shift;
   logic        dout;
   logic        dout_vld;
   logic        underrun;

   int vecs = 0;
   int errs = 0;
   int samp [64];
   bit exp_bits [128];
   bit run_bits [128];

   always #5 clk = ~clk;

   cic_interp_pdm dut (
      .clk        (clk),
      .rst        (rst),
      .clk_en     (clk_en),
      .din        (din),
      .din_valid  (din_valid),
      .din_rdy    (din_rdy),
      .int_num    (int_num),
      .rate_we    (rate_we),
      .norm_shift (norm_shift),
      .dout       (dout),
      .dout_vld   (dout_vld),
      .underrun   (underrun)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rate(input int r, input int sh);
      clk_en     = 1'b0;
      din_valid  = 1'b0;
      int_num    = 16'(r);
      norm_shift = 6'(sh);
      rate_we    = 1'b1;
      step();
      rate_we    = 1'b0;
   endtask

   // Reference: comb at sample rate, zero-stuff, integrate, shift, modulate
   task automatic model_run(input int r, input int sh, input int ns);
      longint d [3];
      longint i1, i2, i3, up, cur, c, yv;
      int     acc, fb, k;
      bit     q;
      for (int j = 0; j < 3; j++) d[j] = 0;
      i1 = 0; i2 = 0; i3 = 0; up = 0;
      acc = 0; q = 1'b0; k = 0;
      for (int s = 0; s < ns; s++) begin
         yv = i3 >>> sh;
         if (yv > 32767) yv = 32767;
         else if (yv < -32768) yv = -32768;
         fb  = q ? 32767 : -32768;
         acc = acc + int'(yv) - fb;
         q   = (acc >= 0);
         exp_bits[s] = q;
         i3 += i2;
         i2 += i1;
         if (s % r == 0) i1 += up;
         if (s % r == r - 1) begin
            cur = longint'(samp[k]);
            k++;
            for (int j = 0; j < 3; j++) begin
               c    = cur - d[j];
               d[j] = cur;
               cur  = c;
            end
            up = cur;
         end
      end
   endtask

   task automatic test_reset();
      step();
      step();
      vecs++;
      if (dout !== 1'b0) begin
         errs++; $display("FAIL reset_dout: got %b want 0", dout);
      end
      vecs++;
      if (dout_vld !== 1'b0) begin
         errs++; $display("FAIL reset_vld: got %b want 0", dout_vld);
      end
      vecs++;
      if (underrun !== 1'b0) begin
         errs++; $display("FAIL reset_underrun: got %b want 0", underrun);
      end
      vecs++;
      if (din_rdy !== 1'b1) begin
         errs++; $display("FAIL reset_rdy: got %b want 1", din_rdy);
      end
      rst = 1'b1;
      step();
      vecs++;
      if (din_rdy !== 1'b1 || dout_vld !== 1'b0) begin
         errs++;
         $display("FAIL idle_after_reset: rdy=%b vld=%b want 1/0",
                  din_rdy, dout_vld);
      end
   endtask

   task automatic test_dc();
      int rdy_cnt, ones;
      din = 16'd16384; din_valid = 1'b1; clk_en = 1'b1;
      step();
      vecs++;
      if (din_rdy !== 1'b0) begin
         errs++; $display("FAIL dc_first_fill: rdy=%b want 0", din_rdy);
      end
      vecs++;
      if (dout_vld !== 1'b1) begin
         errs++; $display("FAIL dc_vld: got %b want 1", dout_vld);
      end
      for (int i = 0; i < 100; i++) step();
      rdy_cnt = 0;
      for (int i = 0; i < 64; i++) begin
         step();
         if (din_rdy) rdy_cnt++;
      end
      vecs++;
      if (rdy_cnt != 16) begin
         errs++; $display("FAIL dc_rdy_rate: got %0d want 16", rdy_cnt);
      end
      ones = 0;
      for (int i = 0; i < 1024; i++) begin
         step();
         if (dout) ones++;
      end
      vecs++;
      if (ones < 758 || ones > 778) begin
         errs++; $display("FAIL dc_density: got %0d/1024 want 768+/-10", ones);
      end
      vecs++;
      if (underrun !== 1'b0) begin
         errs++; $display("FAIL dc_underrun: got %b want 0", underrun);
      end
   endtask

   task automatic test_underrun();
      int n, ones;
      n = 0;
      while (din_rdy !== 1'b1 && n < 16) begin
         step();
         n++;
      end
      vecs++;
      if (din_rdy !== 1'b1) begin
         errs++; $display("FAIL ur_wait_rdy: got %b want 1", din_rdy);
      end
      din_valid = 1'b0;
      step(); step(); step();
      vecs++;
      if (underrun !== 1'b0) begin
         errs++; $display("FAIL ur_early: got %b want 0", underrun);
      end
      step();
      vecs++;
      if (underrun !== 1'b1) begin
         errs++; $display("FAIL ur_on_consume: got %b want 1", underrun);
      end
      din_valid = 1'b1;
      for (int i = 0; i < 100; i++) step();
      ones = 0;
      for (int i = 0; i < 1024; i++) begin
         step();
         if (dout) ones++;
      end
      vecs++;
      if (ones < 758 || ones > 778) begin
         errs++; $display("FAIL ur_density: got %0d/1024 want 768+/-10", ones);
      end
      vecs++;
      if (underrun !== 1'b1) begin
         errs++; $display("FAIL ur_sticky: got %b want 1", underrun);
      end
   endtask

   task automatic test_hold();
      bit bad;
      set_rate(4, 4);
      vecs++;
      if (din_rdy !== 1'b1 || dout !== 1'b0) begin
         errs++; $display("FAIL hold_clear: rdy=%b dout=%b want 1/0", din_rdy, dout);
      end
      vecs++;
      if (underrun !== 1'b1) begin
         errs++; $display("FAIL hold_ur_kept: got %b want 1", underrun);
      end
      din = 16'd16384; din_valid = 1'b1;
      step();
      vecs++;
      if (din_rdy !== 1'b0) begin
         errs++; $display("FAIL hold_xfer: rdy=%b want 0", din_rdy);
      end
      din_valid = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (dout_vld !== 1'b0 || dout !== 1'b0 || din_rdy !== 1'b0) bad = 1'b1;
      end
      vecs++;
      if (bad) begin
         errs++;
         $display("FAIL hold_frozen: vld=%b dout=%b rdy=%b want 0/0/0",
                  dout_vld, dout, din_rdy);
      end
   endtask

   task automatic test_full_scale();
      int ones;
      set_rate(16, 8);
      din = 16'd32767; din_valid = 1'b1; clk_en = 1'b1;
      for (int i = 0; i < 300; i++) step();
      ones = 0;
      for (int i = 0; i < 256; i++) begin
         step();
         if (dout) ones++;
      end
      vecs++;
      if (ones != 256) begin
         errs++; $display("FAIL fs_pos: got %0d ones want 256", ones);
      end
      din = 16'h8000;
      for (int i = 0; i < 300; i++) step();
      ones = 0;
      for (int i = 0; i < 256; i++) begin
         step();
         if (dout) ones++;
      end
      vecs++;
      if (ones != 0) begin
         errs++; $display("FAIL fs_neg: got %0d ones want 0", ones);
      end
   endtask

   task automatic test_rate_change();
      for (int i = 0; i < 7; i++) step();
      int_num = 16'd0; norm_shift = 6'd2; rate_we = 1'b1;
      din = 16'h8000; din_valid = 1'b1; clk_en = 1'b1;
      step();
      rate_we = 1'b0;
      vecs++;
      if (din_rdy !== 1'b1 || dout !== 1'b0) begin
         errs++; $display("FAIL rc_clear: rdy=%b dout=%b want 1/0", din_rdy, dout);
      end
      vecs++;
      if (underrun !== 1'b1) begin
         errs++; $display("FAIL rc_ur_kept: got %b want 1", underrun);
      end
      for (int i = 0; i < 64; i++) samp[i] = 0;
      samp[0] = 1000;
      model_run(2, 2, 40);
      din = 16'd1000;
      for (int s = 0; s < 40; s++) begin
         step();
         din = 16'd0;
         vecs++;
         if (dout !== exp_bits[s]) begin
            errs++;
            $display("FAIL rc_impulse[%0d]: got %b want %b", s, dout, exp_bits[s]);
         end
      end
   endtask

   task automatic test_gated();
      int  idx, s, cyc;
      bit  xf, vbad;
      int  tbl [20] = '{8000, -12000, 20000, 3000, -25000, 0, 15000, -5000,
                        10000, 32767, -32768, 1234, -4321, 7000, -700, 0,
                        500, -500, 2500, -2500};
      for (int i = 0; i < 64; i++) samp[i] = 0;
      for (int i = 0; i < 20; i++) samp[i] = tbl[i];
      model_run(3, 4, 48);
      set_rate(3, 4);
      idx = 0; din = 16'(samp[0]); din_valid = 1'b1; clk_en = 1'b1;
      for (s = 0; s < 48; s++) begin
         xf = din_rdy & din_valid;
         step();
         if (xf) begin idx++; din = 16'(samp[idx]); end
         run_bits[s] = dout;
         vecs++;
         if (dout !== exp_bits[s]) begin
            errs++;
            $display("FAIL gate_ref[%0d]: got %b want %b", s, dout, exp_bits[s]);
         end
      end
      set_rate(3, 4);
      idx = 0; din = 16'(samp[0]); din_valid = 1'b1;
      s = 0; cyc = 0; vbad = 1'b0;
      while (s < 48 && cyc < 500) begin
         clk_en = (cyc % 8 == 7);
         xf = din_rdy & din_valid;
         step();
         if (xf) begin idx++; din = 16'(samp[idx]); end
         if (dout_vld !== clk_en) vbad = 1'b1;
         if (clk_en) begin
            vecs++;
            if (dout !== run_bits[s]) begin
               errs++;
               $display("FAIL gate_dec[%0d]: got %b want %b", s, dout, run_bits[s]);
            end
            s++;
         end
         cyc++;
      end
      vecs++;
      if (s != 48 || vbad) begin
         errs++; $display("FAIL gate_vld: strobes=%0d want 48 vld_bad=%b want 0", s, vbad);
      end
   endtask

   task automatic test_reset_midstream();
      int rdy_cnt, ones;
      din = 16'd16384; din_valid = 1'b1; clk_en = 1'b1;
      for (int i = 0; i < 20; i++) step();
      vecs++;
      if (underrun !== 1'b1) begin
         errs++; $display("FAIL mid_pre_ur: got %b want 1", underrun);
      end
      #3 rst = 1'b0;
      #1;
      vecs++;
      if (underrun !== 1'b0 || dout !== 1'b0 || dout_vld !== 1'b0 || din_rdy !== 1'b1) begin
         errs++;
         $display("FAIL mid_async: ur=%b dout=%b vld=%b rdy=%b want 0/0/0/1",
                  underrun, dout, dout_vld, din_rdy);
      end
      step(); step();
      rst = 1'b1;
      for (int i = 0; i < 100; i++) step();
      rdy_cnt = 0;
      for (int i = 0; i < 64; i++) begin
         step();
         if (din_rdy) rdy_cnt++;
      end
      vecs++;
      if (rdy_cnt != 16) begin
         errs++; $display("FAIL mid_rdy_rate: got %0d want 16", rdy_cnt);
      end
      ones = 0;
      for (int i = 0; i < 1024; i++) begin
         step();
         if (dout) ones++;
      end
      vecs++;
      if (ones < 758 || ones > 778) begin
         errs++; $display("FAIL mid_density: got %0d/1024 want 768+/-10", ones);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; clk_en = 1'b0; din = '0; din_valid = 1'b0;
      int_num = '0; rate_we = 1'b0; norm_shift = '0;
      test_reset();
      test_dc();
      test_underrun();
      test_hold();
      test_full_scale();
      test_rate_change();
      test_gated();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
